arm_lsu_ctrl: RTL

//  Load/store unit for the next-generation ARM core. Sits between core datapath and data memory.

---
 rtl/arm_lsu_ctrl.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/arm_lsu_ctrl.sv
// arm_lsu_ctrl: load/store unit between core datapath and data memory.
// Byte/half/word(/dword) accesses with byte enables, lane-replicated store
// data, alignment fault, wait-state handshake and load sign/zero extension.
// Optional feature macro: LSU_TIMEOUT_EN (bus fault after MAX_WAIT wait cycles).
module arm_lsu_ctrl #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [1:0]          req_size,
  input  logic                req_signed,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                stall,
  output logic                done,
  output logic                fault,
  output logic [DATA_W-1:0]   rdata,
  output logic [ADDR_W-1:0]   memaddr,
  output logic [DATA_W/8-1:0] be,
  output logic                memread,
  output logic                memwrite,
  output logic [DATA_W-1:0]   writedata,
  input  logic [DATA_W-1:0]   readdata,
  input  logic                mem_ready
);

  localparam int unsigned NB = DATA_W / 8;
  localparam int unsigned LO = $clog2(NB);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP, FAULT} state_t;

  state_t              state, state_nxt;
  logic                r_write;
  logic [1:0]          r_size;
  logic                r_signed;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                req_bad;
  logic                timeout;
  logic [DATA_W-1:0]   lane;
  logic [DATA_W-1:0]   ld_ext;
  logic                ld_sign;
  int unsigned         ld_bits;

  // Misaligned address or dword on a 32-bit bus.
  always_comb begin
    req_bad = 1'b0;
    case (req_size)
      2'b01:   req_bad = req_addr[0];
      2'b10:   req_bad = |req_addr[1:0];
      2'b11:   req_bad = (DATA_W == 32) || (|req_addr[2:0]);
      default: req_bad = 1'b0;
    endcase
  end

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned CW = (MAX_WAIT < 16) ? 4 : $clog2(MAX_WAIT + 1);
  logic [CW-1:0] wait_cnt;

  // Wait counter: zero outside ACCESS, counts cycles without mem_ready.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                wait_cnt <= '0;
    else if (state != ACCESS) wait_cnt <= '0;
    else if (!mem_ready)      wait_cnt <= wait_cnt + 1'b1;
  end

  // Fires on the cycle whose miss brings the count to MAX_WAIT.
  assign timeout = !mem_ready && (wait_cnt == CW'(MAX_WAIT - 1));
`else
  assign timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; mem_ready wins over a same-cycle timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = req_bad ? FAULT : ACCESS;
      ACCESS:  if (mem_ready) state_nxt = RESP;
               else if (timeout) state_nxt = FAULT;
      RESP:    state_nxt = IDLE;
      FAULT:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture on acceptance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_write  <= 1'b0;
      r_size   <= '0;
      r_signed <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
    end else if (state == IDLE && req_valid) begin
      r_write  <= req_write;
      r_size   <= req_size;
      r_signed <= req_signed;
      r_addr   <= req_addr;
      r_wdata  <= req_wdata;
    end
  end

  // Load lane extraction and sign/zero extension.
  always_comb begin
    lane = readdata >> {r_addr[LO-1:0], 3'b000};
    case (r_size)
      2'b00:   ld_bits = 8;
      2'b01:   ld_bits = 16;
      2'b10:   ld_bits = 32;
      default: ld_bits = DATA_W;
    endcase
    ld_sign = r_signed & lane[ld_bits-1];
    ld_ext  = lane;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      if (i >= ld_bits) ld_ext[i] = ld_sign;
    end
  end

  // Load result is registered on completion so it is valid in the done cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                        rdata <= '0;
    else if (state == ACCESS && mem_ready && !r_write) rdata <= ld_ext;
  end

  // Output decode from state and registered request.
  always_comb begin
    req_ready = (state == IDLE);
    stall     = (state != IDLE);
    done      = (state == RESP);
    fault     = (state == FAULT);
    memread   = (state == ACCESS) && !r_write;
    memwrite  = (state == ACCESS) && r_write;
    be        = '0;
    if (state == ACCESS) begin
      case (r_size)
        2'b00:   be = NB'(1) << r_addr[LO-1:0];
        2'b01:   be = NB'(3) << r_addr[LO-1:0];
        2'b10:   be = (NB == 8) ? (NB'(15) << {r_addr[2], 2'b00}) : '1;
        default: be = '1;
      endcase
    end
  end

  // Store data replicated across every lane of its size.
  always_comb begin
    case (r_size)
      2'b00:   writedata = {NB{r_wdata[7:0]}};
      2'b01:   writedata = {(NB/2){r_wdata[15:0]}};
      2'b10:   writedata = {(NB/4){r_wdata[31:0]}};
      default: writedata = r_wdata;
    endcase
  end

  assign memaddr = {r_addr[ADDR_W-1:LO], {LO{1'b0}}};

endmodule
